// File: rtl/mod_4051_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 300-bit mod-4051 reducer among NREQ requesters.
// Defining MOD4051_STATS_EN adds the saturating op_count port and register.

module x_300_mod_4051 (
   input  logic [299:0] x_i,
   output logic [11:0]  r_o
);
   // 4096 = 4051 + 45, so folding in each 12-bit chunk from the top is acc*45 + chunk
   function automatic logic [11:0] reduce_300(input logic [299:0] x);
      logic [17:0] acc;
      acc = 18'd0;
      for (int k = 24; k >= 0; k--) begin
         acc = (acc * 18'd45 + {6'd0, x[k*12 +: 12]}) % 18'd4051;
      end
      return acc[11:0];
   endfunction

   assign r_o = reduce_300(x_i);
endmodule

module mod_4051_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int XW   = 300,
   parameter int RW   = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XW-1:0]   req_x,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [NREQ*RW-1:0]   rsp_r
`ifdef MOD4051_STATS_EN
   ,output logic [15:0]         op_count
`endif
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic [PW-1:0]      grant_idx_s;
   logic               grant_s;
   logic [3:0]         cand_s;
   logic [3:0]         next_s;
   logic [NREQ-1:0]    eligible_s;
   logic [NREQ-1:0]    write_s;
   logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [XW-1:0]      op_reg_q, op_reg_d;
   logic [NREQ*RW-1:0] rsp_r_q, rsp_r_d;
   logic [RW-1:0]      red_s;

   x_300_mod_4051 u_reducer (
      .x_i (op_reg_q),
      .r_o (red_s)
   );

   // Arbitration FSM: pick the first eligible requester from rr_ptr, wrapping modulo NREQ
   always_comb begin
      eligible_s  = req_valid & (~rsp_valid_q | rsp_ready);
      grant_s     = 1'b0;
      grant_idx_s = '0;
      cand_s      = 4'd0;
      next_s      = 4'd0;
      req_ready   = '0;
      write_s     = '0;
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      op_reg_d    = op_reg_q;
      case (state_q)
         IDLE: begin
            for (int k = 0; k < NREQ; k++) begin
               cand_s = 4'(rr_ptr_q) + 4'(k);
               if (cand_s >= 4'(NREQ)) begin
                  cand_s = cand_s - 4'(NREQ);
               end else begin
                  cand_s = cand_s;
               end
               if (!grant_s && eligible_s[cand_s[PW-1:0]]) begin
                  grant_s     = 1'b1;
                  grant_idx_s = cand_s[PW-1:0];
               end else begin
                  grant_s     = grant_s;
               end
            end
            if (grant_s) begin
               next_s = 4'(grant_idx_s) + 4'd1;
               if (next_s >= 4'(NREQ)) begin
                  next_s = 4'd0;
               end else begin
                  next_s = next_s;
               end
               req_ready[grant_idx_s] = 1'b1;
               op_reg_d               = req_x[grant_idx_s*XW +: XW];
               owner_d                = grant_idx_s;
               rr_ptr_d               = next_s[PW-1:0];
               state_d                = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            write_s[owner_q] = 1'b1;
            state_d          = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Result slots: a write on the same edge as a consume keeps the slot valid
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_r_d     = rsp_r_q;
      for (int i = 0; i < NREQ; i++) begin
         if (write_s[i]) begin
            rsp_valid_d[i]         = 1'b1;
            rsp_r_d[i*RW +: RW]    = red_s;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i]         = 1'b0;
         end else begin
            rsp_valid_d[i]         = rsp_valid_q[i];
         end
      end
   end

   // State, operand and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         op_reg_q    <= '0;
         rsp_valid_q <= '0;
         rsp_r_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         op_reg_q    <= op_reg_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_r_q     <= rsp_r_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_r     = rsp_r_q;

`ifdef MOD4051_STATS_EN
   logic [15:0] op_count_q;

   // Completed-operation counter, saturating at all ones
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_q <= 16'd0;
      end else if ((state_q == BUSY) && (op_count_q != 16'hFFFF)) begin
         op_count_q <= op_count_q + 16'd1;
      end else begin
         op_count_q <= op_count_q;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mod_4051_rr_arbiter.sv
// Self-checking bench for mod_4051_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbiter and slots.

module tb_mod_4051_rr_arbiter;
   localparam int N  = 4;
   localparam int XW = 300;
   localparam int RW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [N-1:0]      req_valid, rsp_ready;
   logic [N*XW-1:0]   req_x;
   wire  [N-1:0]      req_ready, rsp_valid;
   wire  [N*RW-1:0]   rsp_r;
`ifdef MOD4051_STATS_EN
   wire  [15:0]       op_count;
`endif

   mod_4051_rr_arbiter #(.NREQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_r     (rsp_r)
`ifdef MOD4051_STATS_EN
      ,.op_count (op_count)
`endif
   );

   int total = 0;
   int bad   = 0;
   logic [XW-1:0] nx [N];
   logic [N-1:0]  cap_ready;

   // behavioural model
   bit            m_busy;
   int            m_owner, m_ptr, m_count;
   logic [XW-1:0] m_op;
   bit            m_valid [N];
   int            m_val [N];
   int            glog [$];

   function automatic int ref_mod(input logic [XW-1:0] x);
      int r = 0;
      for (int b = XW-1; b >= 0; b--) r = (r * 2 + int'(x[b])) % 4051;
      return r;
   endfunction

   function automatic logic [XW-1:0] rand300();
      logic [319:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[XW-1:0];
   endfunction

   function automatic int m_grant();
      int i;
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (req_valid[i] && (!m_valid[i] || rsp_ready[i])) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_count = 0; m_op = '0;
      for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_val[i] = 0; end
   endtask

   task automatic model_step();
      int g;
      if (rst) begin
         m_reset();
         return;
      end
      g = m_busy ? -1 : m_grant();
      for (int i = 0; i < N; i++) if (m_valid[i] && rsp_ready[i]) m_valid[i] = 1'b0;
      if (m_busy) begin
         m_val[m_owner]   = ref_mod(m_op);
         m_valid[m_owner] = 1'b1;
         m_busy           = 1'b0;
         if (m_count < 65535) m_count++;
      end else if (g >= 0) begin
         m_op    = req_x[g*XW +: XW];
         m_owner = g;
         m_ptr   = (g + 1) % N;
         m_busy  = 1'b1;
         glog.push_back(g);
      end
   endtask

   task automatic check_all();
      int g;
      logic [N-1:0] er, ev;
      g  = m_busy ? -1 : m_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int i = 0; i < N; i++) ev[i] = m_valid[i];
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      for (int i = 0; i < N; i++) chk("rsp_r", 64'(rsp_r[i*RW +: RW]), 64'(m_val[i]));
`ifdef MOD4051_STATS_EN
      chk("op_count", 64'(op_count), 64'(m_count));
`endif
   endtask

   task automatic do_cycle(input logic [N-1:0] v, input logic [N-1:0] rr, input logic r);
      @(negedge clk);
      rst = r; req_valid = v; rsp_ready = rr;
      for (int i = 0; i < N; i++) req_x[i*XW +: XW] = nx[i];
      #1;
      cap_ready = req_ready;
      check_all();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      int mark, pos, ones, sel;
      logic [XW-1:0] sp [6];
      rst = 1'b1; req_valid = '0; rsp_ready = '0; req_x = '0;
      for (int i = 0; i < N; i++) nx[i] = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_r", 64'(rsp_r[47:0]), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);

      // model pinned against hand-computed residues
      chk("ref_4096", 64'(ref_mod(300'd4096)), 64'd45);
      chk("ref_2p24", 64'(ref_mod(300'd16777216)), 64'd2025);
      chk("ref_8102", 64'(ref_mod(300'd8102)), 64'd0);

      // single request latency
      nx[0] = 300'd4096;
      do_cycle(4'b0001, 4'b0000, 1'b0);
      chk("t1_ready_grant", 64'(cap_ready), 64'd1);
      #1 chk("t1_not_yet_valid", 64'(rsp_valid), 64'd0);
      do_cycle(4'b0000, 4'b0000, 1'b0);
      chk("t1_ready_busy", 64'(cap_ready), 64'd0);
      #1;
      chk("t1_valid", 64'(rsp_valid), 64'd1);
      chk("t1_result", 64'(rsp_r[11:0]), 64'd45);

      // operand values
      sp[0] = 300'd16777216; sp[1] = 300'd4051; sp[2] = 300'd4050;
      sp[3] = 300'd0;        sp[4] = 300'd8102; sp[5] = '1;
      for (int k = 0; k < 5; k++) begin
         int expv [5] = '{2025, 0, 4050, 0, 0};
         nx[0] = sp[k];
         do_cycle(4'b0001, 4'b0001, 1'b0);
         do_cycle(4'b0000, 4'b0001, 1'b0);
         #1 chk("t2_value", 64'(rsp_r[11:0]), 64'(expv[k]));
      end

      // all requesters busy, slots always drained
      for (int i = 0; i < N; i++) nx[i] = rand300();
      do_cycle(4'b0000, 4'b0000, 1'b1);
      glog.delete();
      repeat (16) do_cycle(4'b1111, 4'b1111, 1'b0);
      chk("t3_grants", 64'(glog.size()), 64'd8);
      for (int k = 0; k < 8; k++) chk("t3_order", 64'(glog[k]), 64'(k % 4));

      // backpressure on requester 1
      do_cycle(4'b0000, 4'b0000, 1'b1);
      glog.delete();
      repeat (20) do_cycle(4'b1111, 4'b1101, 1'b0);
      ones = 0;
      foreach (glog[k]) if (glog[k] == 1) ones++;
      chk("t4_req1_once", 64'(ones), 64'd1);
      chk("t4_grants", 64'(glog.size()), 64'd10);
      mark = glog.size();
      do_cycle(4'b1111, 4'b1111, 1'b0);
      repeat (8) do_cycle(4'b1111, 4'b1101, 1'b0);
      pos = -1;
      for (int k = mark; k < glog.size(); k++) if (pos < 0 && glog[k] == 1) pos = k;
      chk("t4_regrant", 64'((pos >= 0) && (pos - mark < 4)), 64'd1);

      // write and consume of slot 2 on the same edge
      do_cycle(4'b0000, 4'b0000, 1'b1);
      nx[2] = 300'd100;
      do_cycle(4'b0100, 4'b0000, 1'b0);
      do_cycle(4'b0000, 4'b0000, 1'b0);
      #1 chk("t5_first", 64'(rsp_r[35:24]), 64'd100);
      nx[2] = 300'd5000;
      do_cycle(4'b0100, 4'b0100, 1'b0);
      do_cycle(4'b0000, 4'b0100, 1'b0);
      #1;
      chk("t5_valid_kept", 64'(rsp_valid[2]), 64'd1);
      chk("t5_new_value", 64'(rsp_r[35:24]), 64'd949);
      do_cycle(4'b0000, 4'b0100, 1'b0);
      #1 chk("t5_consumed", 64'(rsp_valid[2]), 64'd0);

      // reset while BUSY
      do_cycle(4'b0000, 4'b0000, 1'b1);
      nx[0] = 300'd7; nx[1] = 300'd9;
      do_cycle(4'b0001, 4'b0000, 1'b0);
      do_cycle(4'b0000, 4'b0000, 1'b0);
      do_cycle(4'b0010, 4'b0000, 1'b0);
      do_cycle(4'b0000, 4'b0000, 1'b1);
      #1 chk("t6_valid_cleared", 64'(rsp_valid), 64'd0);
`ifdef MOD4051_STATS_EN
      chk("t6_op_count", 64'(op_count), 64'd0);
`endif
      do_cycle(4'b0000, 4'b0000, 1'b0);
      #1 chk("t6_no_result", 64'(rsp_valid), 64'd0);
      do_cycle(4'b1111, 4'b0000, 1'b0);
      chk("t6_grant0", 64'(cap_ready), 64'd1);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            sel = $urandom_range(0, 7);
            nx[i] = (sel < 6) ? sp[sel] : rand300();
            if ($urandom_range(0, 1) == 1) nx[i] = rand300();
         end
         do_cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 63) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
